// File: rtl/txrx_buf_if.sv
// Producer/consumer bundle for txrx_buf: write handshake, show-ahead read
// port, fill level and the sticky overflow flag.
interface txrx_buf_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              vi;
    logic [DATA_W-1:0] sdata;
    logic              snt;
    logic              full;
    logic              vo;
    logic [DATA_W-1:0] rdata;
    logic              rack;
    logic [LW-1:0]     level;
    logic              ovf;
    logic              ovf_clr;

    modport master (
        output vi, sdata, rack, ovf_clr,
        input  snt, full, vo, rdata, level, ovf
    );

    modport slave (
        input  vi, sdata, rack, ovf_clr,
        output snt, full, vo, rdata, level, ovf
    );
endinterface

// File: rtl/txrx_buf.sv
// Small show-ahead FIFO between a producer and a consumer, with a
// selectable full policy (reject newest or overwrite oldest) and a sticky overflow flag.
module txrx_buf #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int OVF_MODE = 0
) (
    input logic   clk,
    input logic   reset_n,
    txrx_buf_if.slave bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam int            LW       = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              snt_q, snt_d;
    logic              ovf_q, ovf_d;

    logic full_w, vo_w, rd_en, wr_acc, ovf_set, wr_ovr, wr_en, rd_adv;

    assign full_w  = (level_q == FULL_LVL);
    assign vo_w    = (level_q != '0);
    assign rd_en   = vo_w & bus.rack;
    assign wr_acc  = bus.vi & (~full_w | rd_en);
    assign ovf_set = bus.vi & full_w & ~rd_en;
    // In overwrite mode a blocked write evicts the oldest entry instead.
    assign wr_ovr  = (OVF_MODE == 1) & ovf_set;
    assign wr_en   = wr_acc | wr_ovr;
    assign rd_adv  = rd_en | wr_ovr;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves it unassigned (no latch).
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc && !rd_en) begin
            level_d = level_q + LW'(1);
        end else if (rd_en && !wr_acc) begin
            level_d = level_q - LW'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        snt_d = wr_en;
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            snt_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            snt_q    <= snt_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage is deliberately not reset; level==0 already masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.sdata;
        end
    end

    assign bus.snt   = snt_q;
    assign bus.full  = full_w;
    assign bus.vo    = vo_w;
    assign bus.level = level_q;
    assign bus.ovf   = ovf_q;
    assign bus.rdata = vo_w ? mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_txrx_buf.sv
// Scoreboard bench for txrx_buf: one reject-mode and one overwrite-mode
// instance, directed vectors, and read-side monitors checking data order.
module tb_txrx_buf;
    logic clk;
    logic reset_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    txrx_buf_if #(.DATA_W(8), .DEPTH(4)) bus0 ();
    txrx_buf_if #(.DATA_W(8), .DEPTH(4)) bus1 ();

    txrx_buf #(.DATA_W(8), .DEPTH(4), .OVF_MODE(0)) u_rej (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    txrx_buf #(.DATA_W(8), .DEPTH(4), .OVF_MODE(1)) u_ovw (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: a read happens at the next rising edge when vo & rack hold now.
    always @(negedge clk) begin
        if (reset_n && bus0.vo && bus0.rack) begin
            if (exp_q0.size() == 0) begin
                check("rd0_unexpected", {24'd0, bus0.rdata}, 32'hFFFF_FFFF);
            end else begin
                automatic logic [7:0] e = exp_q0.pop_front();
                check("rd0_data", {24'd0, bus0.rdata}, {24'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && bus1.vo && bus1.rack) begin
            if (exp_q1.size() == 0) begin
                check("rd1_unexpected", {24'd0, bus1.rdata}, 32'hFFFF_FFFF);
            end else begin
                automatic logic [7:0] e = exp_q1.pop_front();
                check("rd1_data", {24'd0, bus1.rdata}, {24'd0, e});
            end
        end
    end

    task automatic idle_inputs();
        bus0.vi = 1'b0; bus0.sdata = '0; bus0.rack = 1'b0; bus0.ovf_clr = 1'b0;
        bus1.vi = 1'b0; bus1.sdata = '0; bus1.rack = 1'b0; bus1.ovf_clr = 1'b0;
    endtask

    // One clock cycle of stimulus on the selected instance; returns 1 time unit after the edge.
    task automatic cyc(input bit sel, input logic vi, input logic [7:0] d,
                       input logic rack, input logic clr);
        if (!sel) begin
            bus0.vi = vi; bus0.sdata = d; bus0.rack = rack; bus0.ovf_clr = clr;
        end else begin
            bus1.vi = vi; bus1.sdata = d; bus1.rack = rack; bus1.ovf_clr = clr;
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check("rst_vo0",    bus0.vo,    0);
        check("rst_lvl0",   bus0.level, 0);
        check("rst_full0",  bus0.full,  0);
        check("rst_snt0",   bus0.snt,   0);
        check("rst_ovf0",   bus0.ovf,   0);
        check("rst_rdata0", bus0.rdata, 0);
        check("rst_vo1",    bus1.vo,    0);
        check("rst_lvl1",   bus1.level, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Single transfer
        exp_q0.push_back(8'hFF);
        cyc(0, 1, 8'hFF, 0, 0);
        check("single_snt",   bus0.snt,   1);
        check("single_vo",    bus0.vo,    1);
        check("single_rdata", bus0.rdata, 8'hFF);
        check("single_lvl",   bus0.level, 1);
        cyc(0, 0, 0, 1, 0);
        check("single_vo_after",    bus0.vo,    0);
        check("single_rdata_after", bus0.rdata, 0);
        check("single_lvl_after",   bus0.level, 0);
        check("single_snt_after",   bus0.snt,   0);

        // rack while empty is ignored
        cyc(0, 0, 0, 1, 0);
        check("empty_rack_lvl", bus0.level, 0);

        // Fill and reject; the 5th write also asserts ovf_clr (set wins)
        for (int i = 1; i <= 4; i++) begin
            exp_q0.push_back(8'(i));
            cyc(0, 1, 8'(i), 0, 0);
            check("fill_snt", bus0.snt, 1);
            check("fill_lvl", bus0.level, 32'(i));
            check("fill_full", bus0.full, (i == 4) ? 1 : 0);
        end
        cyc(0, 1, 8'd5, 0, 1);
        check("reject_snt",  bus0.snt,   0);
        check("reject_ovf",  bus0.ovf,   1);
        check("reject_lvl",  bus0.level, 4);
        check("reject_full", bus0.full,  1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        check("reject_drain_lvl", bus0.level, 0);
        check("reject_ovf_kept",  bus0.ovf,   1);
        cyc(0, 0, 0, 0, 1);
        check("ovf_clr", bus0.ovf, 0);

        // Overwrite mode: 1..6 leaves 3,4,5,6
        for (int i = 1; i <= 6; i++) begin
            cyc(1, 1, 8'(i), 0, 0);
            check("ovw_snt", bus1.snt, 1);
        end
        exp_q1.push_back(8'd3);
        exp_q1.push_back(8'd4);
        exp_q1.push_back(8'd5);
        exp_q1.push_back(8'd6);
        check("ovw_lvl",  bus1.level, 4);
        check("ovw_ovf",  bus1.ovf,   1);
        check("ovw_full", bus1.full,  1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);
        check("ovw_drain_lvl", bus1.level, 0);

        // Simultaneous write+read while full
        for (int i = 0; i < 4; i++) begin
            exp_q0.push_back(8'h10 + 8'(i));
            cyc(0, 1, 8'h10 + 8'(i), 0, 0);
        end
        exp_q0.push_back(8'h14);
        cyc(0, 1, 8'h14, 1, 0);
        check("simul_snt",  bus0.snt,   1);
        check("simul_lvl",  bus0.level, 4);
        check("simul_ovf",  bus0.ovf,   0);
        check("simul_full", bus0.full,  1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        check("simul_drain_lvl", bus0.level, 0);

        // Wrap-around: 3*DEPTH+1 words streamed with rack held high
        for (int i = 0; i < 13; i++) begin
            exp_q0.push_back(8'h20 + 8'(i));
            cyc(0, 1, 8'h20 + 8'(i), 1, 0);
            check("wrap_lvl", bus0.level, 1);
            check("wrap_snt", bus0.snt,   1);
        end
        cyc(0, 0, 0, 1, 0);
        check("wrap_drain_lvl", bus0.level, 0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'hA0 + 8'(i), 0, 0);
        check("pre_rst_lvl", bus0.level, 3);
        check("pre_rst_ovf1", bus1.ovf, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_vo",    bus0.vo,    0);
        check("async_rst_lvl",   bus0.level, 0);
        check("async_rst_rdata", bus0.rdata, 0);
        check("async_rst_ovf1",  bus1.ovf,   0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        exp_q0.push_back(8'h5A);
        cyc(0, 1, 8'h5A, 0, 0);
        check("post_rst_rdata", bus0.rdata, 8'h5A);
        check("post_rst_lvl",   bus0.level, 1);
        cyc(0, 0, 0, 1, 0);
        check("post_rst_lvl_after", bus0.level, 0);

        repeat (2) @(posedge clk);
        check("sb0_empty", exp_q0.size(), 0);
        check("sb1_empty", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/txrx_buf.md
TXRX_BUF -- requirements
Module: txrx_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the transferred word.
REQ-002 SHALL have parameter DEPTH, default 4: buffer entries; power of 2, >= 2.
REQ-003 SHALL have parameter OVF_MODE, default 0: 0 = reject new word when full; 1 = overwrite the oldest word when full.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port vi  in  1  producer word valid, one word per high cycle.
REQ-007 SHALL have port sdata  in  DATA_W  producer word, sampled when vi=1.
REQ-008 SHALL have port snt  out  1  registered one-cycle pulse: a word was accepted.
REQ-009 SHALL have port full  out  1  level == DEPTH.
REQ-010 SHALL have port vo  out  1  word available (level != 0).
REQ-011 SHALL have port rdata  out  DATA_W  oldest stored word (show-ahead).
REQ-012 SHALL have port rack  in  1  consumer takes rdata when vo=1 and rack=1.
REQ-013 SHALL have port level  out  clog2(DEPTH)+1  number of stored words.
REQ-014 SHALL have port ovf  out  1  sticky flag: a word was rejected or overwritten.
REQ-015 SHALL have port ovf_clr  in  1  synchronous clear of ovf.

Function
REQ-016 SHALL define read = vo & rack; rack while vo=0 SHALL be ignored, with no state change.
REQ-017 SHALL accept a write when vi=1 and (full=0 or read=1); on accept, store sdata at wr_ptr and advance wr_ptr modulo DEPTH.
REQ-018 SHALL, on read, advance rd_ptr modulo DEPTH; pointers wrap DEPTH-1 -> 0.
REQ-019 SHALL update level as +1 on write only, -1 on read only, and unchanged on simultaneous write+read (including when full).
REQ-020 SHALL, when OVF_MODE=0, vi=1, full=1 and read=0: reject the word, leave storage unchanged, keep snt low, and set ovf.
REQ-021 SHALL, when OVF_MODE=1, vi=1, full=1 and read=0: write sdata over the oldest entry, advance both pointers, leave level = DEPTH, assert snt, and set ovf.
REQ-022 SHALL assert snt in the cycle after the accepting edge, for exactly one cycle per accepted word.
REQ-023 SHALL present a word written at edge N on vo/rdata from edge N onward (one-cycle latency); no combinational vi->vo bypass when empty.
REQ-024 SHALL drive rdata to 0 while vo=0.
REQ-025 SHALL give set priority over clear when ovf_clr=1 and a set condition occur in the same cycle.
REQ-026 SHALL derive full, vo and level from registered state only; no combinational path from vi or rack to any output.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force pointers=0, level=0, snt=0, ovf=0, vo=0, full=0 and rdata=0; storage contents are not reset.
REQ-028 SHALL start operating on the first rising clk edge after reset_n deasserts; reset asserted mid-transfer SHALL discard all stored words.

Verification
REQ-029 SHALL cover single transfer: DATA_W=8, vi pulse with sdata=8'hFF -> snt pulse one cycle later, vo=1, rdata=8'hFF, level=1; rack=1 -> vo=0, rdata=0, level=0.
REQ-030 SHALL cover fill and reject: OVF_MODE=0, DEPTH=4, write 1,2,3,4,5 without rack -> full=1 after 4th, 5th gets no snt, ovf=1; reads return 1,2,3,4.
REQ-031 SHALL cover overwrite: OVF_MODE=1, DEPTH=4, write 1..6 without rack -> level=4, ovf=1, 6 snt pulses; reads return 3,4,5,6.
REQ-032 SHALL cover simultaneous write+read when full: full buffer, vi=1 and rack=1 in the same cycle -> snt=1, level stays 4, ovf stays 0, FIFO order preserved.
REQ-033 SHALL cover wrap-around: 3*DEPTH+1 words streamed with rack held high -> every word delivered in order, level never exceeds 1.
REQ-034 SHALL cover reset mid-operation: reset_n low with level=3 -> vo=0, level=0, ovf=0 immediately without a clock edge; next write reads back correctly.
